spi_xfer_sequencer: RTL and testbench
=====================================

Name: spi_xfer_sequencer

Overview:
Upstream companion to spi_leader.
- Accepts words from the host over a valid/ready stream and buffers them in a TX FIFO.
- Launches one spi_leader transfer per word by pulsing go with tx_data held stable.
- Captures each rx_data on done into an RX FIFO, drained by the host over valid/ready.
- Enforces a programmable inter-transfer gap and never launches a transfer whose result cannot be stored.

Parameters:
DATA_LEN, 8, SPI word width; must match spi_leader.
FIFO_DEPTH, 4, entries per FIFO; power of two, minimum 2.
GAP_CYCLES, 5, idle sys_clk cycles between done and the next go; 0 means no gap.

Ports:
sys_clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  allows new transfers to launch
tx_valid  in  1  host TX word valid
tx_ready  out  1  TX FIFO not full
tx_data  in  DATA_LEN  host TX word
rx_valid  out  1  RX FIFO not empty
rx_ready  in  1  host consumes RX word
rx_data  out  DATA_LEN  RX FIFO head word
spi_go  out  1  one-cycle start pulse to spi_leader
spi_tx_data  out  DATA_LEN  word to spi_leader
spi_done  in  1  spi_leader completion pulse; spi_rx_data valid in the same cycle
spi_rx_data  in  DATA_LEN  word from spi_leader
tx_level  out  $clog2(FIFO_DEPTH)+1  TX FIFO occupancy
rx_level  out  $clog2(FIFO_DEPTH)+1  RX FIFO occupancy
idle  out  1  high in IDLE with TX FIFO empty

Behaviour:
- Reset (async, rst_n=0): both FIFOs empty, FSM in IDLE, spi_go=0, spi_tx_data=0, rx_valid=0, rx_data=0, tx_level=0, rx_level=0, tx_ready=1, idle=1. Reset mid-transfer abandons the in-flight word. No RX entry is written.
- TX push: occurs when tx_valid&&tx_ready at the sys_clk edge. tx_ready=(tx_level<FIFO_DEPTH), derived from registered count. tx_valid while full is ignored and nothing is overwritten.
- RX pop: occurs when rx_valid&&rx_ready. rx_data shows the head with no extra latency (first-word fall-through). rx_ready while empty has no effect.
- FIFO bypass: none. A word pushed at edge N is visible to the FSM at N+1.
- FSM states: IDLE, LAUNCH, WAIT_DONE, GAP.
- IDLE->LAUNCH: when enable && tx_level!=0 && rx_level<FIFO_DEPTH. On that edge the TX head is popped into spi_tx_data.
- LAUNCH: spi_go=1 for exactly this one cycle, then WAIT_DONE.
- WAIT_DONE: spi_tx_data held stable. On spi_done, spi_rx_data is pushed into the RX FIFO. Space is guaranteed by the launch check. Then GAP, or IDLE if GAP_CYCLES==0.
- GAP: counter loads GAP_CYCLES-1 and counts down to 0, then IDLE.
- Latency: a word pushed into an empty FIFO in IDLE at edge N gives spi_go high during cycle N+2.
- Back-to-back: successive go pulses are separated by at least GAP_CYCLES+2 cycles after done.
- enable deasserted mid-transfer: the current transfer completes and stores its result, then the FSM holds in IDLE.
- spi_done outside WAIT_DONE: ignored.
- Simultaneous RX push and pop: level unchanged, data order preserved.
- Simultaneous TX push and FSM pop: level unchanged.
- Pointers wrap modulo FIFO_DEPTH. Levels range 0..FIFO_DEPTH.

Optional Feature:
Macro SPI_SEQ_STATS_EN.
- Defined: adds output xfer_count [15:0], reset 0, incremented on each accepted spi_done, wrapping 0xFFFF->0. Adds output stall_cycles [15:0], incremented each cycle in IDLE with enable && tx_level!=0 && rx_level==FIFO_DEPTH, saturating at 0xFFFF.
- Undefined: neither port exists and no counter logic is generated.

Decomposition:
- Package spi_seq_pkg holds:
  - FSM state enum (IDLE=0, LAUNCH=1, WAIT_DONE=2, GAP=3);
  - level-width constant function;
  - gap-counter width derived from GAP_CYCLES (minimum 1 bit).
- Sub-module spi_sync_fifo (DATA_LEN, FIFO_DEPTH; push/pop/full/empty/level, first-word fall-through, async active-low reset), instantiated twice for TX and RX.

Test Plan:
- Single word: reset, push 0xA5 with follower tx 0x5A and enable=1 -> spi_go pulses once, 8 sclk pulses, rx_valid=1, rx_data=0x5A, idle=1 afterwards.
- Burst: push 0x01,0x02,0x03,0x04 with tx_ready staying 1 and spi_leader looped back to follower echo -> four transfers in order, go pulses ≥ GAP_CYCLES+2 cycles after each done, RX pops in order.
- RX full stall: FIFO_DEPTH=4, rx_ready=0, push 6 words -> exactly 4 transfers, rx_level=4, tx_level=2, no go pulse. Then pop one -> exactly one more transfer launches.
- Enable gating: enable=0, push 0x3C -> no go for 100 cycles. Set enable=1 -> go within 2 cycles. Deassert enable during WAIT_DONE -> result 0x3C-exchange still stored.
- Reset mid-transfer: assert rst_n=0 during WAIT_DONE -> all levels 0, spi_go=0, rx_valid=0 immediately (async). No RX entry after release.
- STATS (SPI_SEQ_STATS_EN): 3 transfers -> xfer_count=3. RX full with TX pending for 10 cycles -> stall_cycles=10.

Source files
------------

// File: rtl/spi_seq_pkg.sv
// Shared types and sizing helpers for the SPI transfer sequencer and its FIFOs.
package spi_seq_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } seq_state_t;

    // Occupancy needs one more bit than the pointers so that "full" is representable.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // The gap counter only ever holds GAP_CYCLES-1 down to 0.
    function automatic int gap_cnt_w(input int gap);
        return (gap <= 2) ? 1 : $clog2(gap);
    endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Synchronous first-word fall-through FIFO; push while full and pop while empty are ignored.
module spi_sync_fifo
    import spi_seq_pkg::*;
#(
    parameter int DATA_LEN   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [DATA_LEN-1:0]            push_data,
    input  logic                           pop,
    output logic [DATA_LEN-1:0]            pop_data,
    output logic                           full,
    output logic                           empty,
    output logic [level_w(FIFO_DEPTH)-1:0] level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = level_w(FIFO_DEPTH);

    logic [DATA_LEN-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [LW-1:0]       count;
    logic                do_push;
    logic                do_pop;

    assign full     = (count == LW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign level    = count;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is datapath only; occupancy tracking makes stale contents unobservable.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Feeds spi_leader one word per transfer from a TX FIFO and collects results in an RX FIFO.
// Optional statistics outputs (xfer_count, stall_cycles) are built when SPI_SEQ_STATS_EN is defined.
module spi_xfer_sequencer
    import spi_seq_pkg::*;
#(
    parameter int DATA_LEN   = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 5
) (
    input  logic                      sys_clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    input  logic [DATA_LEN-1:0]       tx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic [DATA_LEN-1:0]       rx_data,
    output logic                      spi_go,
    output logic [DATA_LEN-1:0]       spi_tx_data,
    input  logic                      spi_done,
    input  logic [DATA_LEN-1:0]       spi_rx_data,
    output logic [$clog2(FIFO_DEPTH):0] tx_level,
    output logic [$clog2(FIFO_DEPTH):0] rx_level,
    output logic                      idle
`ifdef SPI_SEQ_STATS_EN
    ,
    output logic [15:0]               xfer_count,
    output logic [15:0]               stall_cycles
`endif
);

    localparam int GW = gap_cnt_w(GAP_CYCLES);
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    seq_state_t          state, state_nxt;
    logic [GW-1:0]       gap_cnt;
    logic [DATA_LEN-1:0] tx_head;
    logic                tx_full, tx_empty, rx_full, rx_empty;
    logic                launch_ok, tx_pop, rx_push;

    spi_sync_fifo #(.DATA_LEN(DATA_LEN), .FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (sys_clk),
        .rst_n     (rst_n),
        .push      (tx_valid),
        .push_data (tx_data),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .level     (tx_level)
    );

    spi_sync_fifo #(.DATA_LEN(DATA_LEN), .FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (sys_clk),
        .rst_n     (rst_n),
        .push      (rx_push),
        .push_data (spi_rx_data),
        .pop       (rx_ready),
        .pop_data  (rx_data),
        .full      (rx_full),
        .empty     (rx_empty),
        .level     (rx_level)
    );

    assign tx_ready  = !tx_full;
    assign rx_valid  = !rx_empty;
    // Reserving RX space at launch is what lets WAIT_DONE push unconditionally.
    assign launch_ok = enable && !tx_empty && !rx_full;
    assign tx_pop    = (state == IDLE) && launch_ok;
    assign rx_push   = (state == WAIT_DONE) && spi_done;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        spi_go    = 1'b0;
        idle      = 1'b0;
        case (state)
            IDLE: begin
                idle = tx_empty;
                if (launch_ok) state_nxt = LAUNCH;
            end
            LAUNCH: begin
                spi_go    = 1'b1;
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (spi_done) state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
            end
            GAP: begin
                if (gap_cnt == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt     <= '0;
            spi_tx_data <= '0;
        end else begin
            if (rx_push)
                gap_cnt <= GAP_LOAD;
            else if ((state == GAP) && (gap_cnt != '0))
                gap_cnt <= gap_cnt - 1'b1;
            if (tx_pop) spi_tx_data <= tx_head;
        end
    end

`ifdef SPI_SEQ_STATS_EN
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count   <= '0;
            stall_cycles <= '0;
        end else begin
            if (rx_push) xfer_count <= xfer_count + 1'b1;
            if ((state == IDLE) && enable && !tx_empty && rx_full && (stall_cycles != 16'hFFFF))
                stall_cycles <= stall_cycles + 1'b1;
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Scoreboard bench for spi_xfer_sequencer with a behavioural spi_leader that answers ~tx_word.
module tb_spi_xfer_sequencer;

    localparam int DL  = 8;
    localparam int FD  = 4;
    localparam int GC  = 5;
    localparam int LW  = $clog2(FD) + 1;
    localparam int LAT = 12;

    logic          sys_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          tx_valid = 1'b0;
    logic          rx_ready = 1'b0;
    logic          spi_done = 1'b0;
    logic [DL-1:0] tx_data = '0;
    logic [DL-1:0] spi_rx_data = '0;
    logic          tx_ready, rx_valid, spi_go, idle;
    logic [DL-1:0] rx_data, spi_tx_data;
    logic [LW-1:0] tx_level, rx_level;
`ifdef SPI_SEQ_STATS_EN
    logic [15:0]   xfer_count, stall_cycles;
`endif

    int            tests = 0;
    int            fails = 0;
    logic [DL-1:0] exp_q[$];
    int            go_cnt = 0;
    int            cyc = 0;
    int            last_done = -1000;
    int            slv_cnt = 0;
    logic [DL-1:0] slv_tx = '0;
    logic          prev_go = 1'b0;
    logic          inject_done = 1'b0;

    spi_xfer_sequencer #(.DATA_LEN(DL), .FIFO_DEPTH(FD), .GAP_CYCLES(GC)) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .spi_go      (spi_go),
        .spi_tx_data (spi_tx_data),
        .spi_done    (spi_done),
        .spi_rx_data (spi_rx_data),
        .tx_level    (tx_level),
        .rx_level    (rx_level),
        .idle        (idle)
`ifdef SPI_SEQ_STATS_EN
        ,
        .xfer_count  (xfer_count),
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        if (obs !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic push_word(input logic [DL-1:0] d);
        int n = 0;
        while (!tx_ready && n < 500) begin
            tick(1);
            n++;
        end
        check("push_ready", 32'(tx_ready), 32'd1);
        tx_valid = 1'b1;
        tx_data  = d;
        if (tx_ready) exp_q.push_back(~d);
        tick(1);
        tx_valid = 1'b0;
    endtask

    // spi_leader stand-in: go starts a LAT-cycle exchange that returns the inverted word.
    initial begin
        forever begin
            @(negedge sys_clk);
            cyc++;
            spi_done = 1'b0;
            if (!rst_n) begin
                slv_cnt = 0;
                prev_go = 1'b0;
            end else begin
                if (spi_go) begin
                    check("go_single", 32'(prev_go), 32'd0);
                    check("go_gap", 32'((cyc - last_done) >= GC + 2), 32'd1);
                    go_cnt++;
                    slv_tx  = spi_tx_data;
                    slv_cnt = LAT;
                end else if (slv_cnt > 0) begin
                    check("tx_stable", 32'(spi_tx_data), 32'(slv_tx));
                    slv_cnt--;
                    if (slv_cnt == 0) begin
                        spi_done    = 1'b1;
                        spi_rx_data = ~slv_tx;
                        last_done   = cyc;
                    end
                end else if (inject_done) begin
                    spi_done    = 1'b1;
                    spi_rx_data = 8'hEE;
                    inject_done = 1'b0;
                end
                prev_go = spi_go;
            end
        end
    end

    always @(negedge sys_clk) begin
        if (rst_n && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) check("rx_unexpected", 32'(exp_q.size()), 32'd1);
            else                   check("rx_order", 32'(rx_data), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        int n;
        int g0;
`ifdef SPI_SEQ_STATS_EN
        logic [15:0] s0;
`endif
        tick(2);
        check("rst_go", 32'(spi_go), 32'd0);
        check("rst_txd", 32'(spi_tx_data), 32'd0);
        check("rst_rxv", 32'(rx_valid), 32'd0);
        check("rst_rxd", 32'(rx_data), 32'd0);
        check("rst_txl", 32'(tx_level), 32'd0);
        check("rst_rxl", 32'(rx_level), 32'd0);
        check("rst_txr", 32'(tx_ready), 32'd1);
        check("rst_idle", 32'(idle), 32'd1);
        rst_n = 1'b1;
        tick(2);

        // Single word and launch latency
        enable = 1'b1;
        push_word(8'hA5);
        check("lat_n1_go", 32'(spi_go), 32'd0);
        check("lat_n1_lvl", 32'(tx_level), 32'd1);
        tick(1);
        check("lat_n2_go", 32'(spi_go), 32'd1);
        check("lat_txd", 32'(spi_tx_data), 32'hA5);
        tick(1);
        check("go_drop", 32'(spi_go), 32'd0);
        n = 0;
        while (!rx_valid && n < 100) begin tick(1); n++; end
        check("single_rxv", 32'(rx_valid), 32'd1);
        check("single_rxd", 32'(rx_data), 32'h5A);
        n = 0;
        while (!idle && n < 100) begin tick(1); n++; end
        check("single_idle", 32'(idle), 32'd1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        check("single_drained", 32'(rx_level), 32'd0);

        // Burst with the host draining continuously
        rx_ready = 1'b1;
        g0 = go_cnt;
        for (int i = 1; i <= 4; i++) begin
            check("burst_rdy", 32'(tx_ready), 32'd1);
            push_word(DL'(i));
        end
        n = 0;
        while (!(exp_q.size() == 0 && idle && slv_cnt == 0) && n < 1000) begin tick(1); n++; end
        check("burst_done", 32'(exp_q.size() == 0 && idle), 32'd1);
        check("burst_gos", 32'(go_cnt - g0), 32'd4);
        rx_ready = 1'b0;

        // RX full stalls launches
        g0 = go_cnt;
        for (int i = 0; i < 6; i++) push_word(DL'(8'h10 + i));
        n = 0;
        while (rx_level != LW'(FD) && n < 1000) begin tick(1); n++; end
        tick(60);
        check("stall_gos", 32'(go_cnt - g0), 32'd4);
        check("stall_rxl", 32'(rx_level), 32'(FD));
        check("stall_txl", 32'(tx_level), 32'd2);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(60);
        check("unstall_gos", 32'(go_cnt - g0), 32'd5);
        check("unstall_rxl", 32'(rx_level), 32'(FD));
        check("unstall_txl", 32'(tx_level), 32'd1);
        rx_ready = 1'b1;
        n = 0;
        while (!(exp_q.size() == 0 && idle && slv_cnt == 0) && n < 1000) begin tick(1); n++; end
        rx_ready = 1'b0;
        check("stall_drain", 32'(rx_level), 32'd0);

        // Stray done while idle
        inject_done = 1'b1;
        tick(3);
        check("stray_rxl", 32'(rx_level), 32'd0);
        check("stray_rxv", 32'(rx_valid), 32'd0);

        // Enable gating
        enable = 1'b0;
        g0 = go_cnt;
        push_word(8'h3C);
        tick(100);
        check("gate_gos", 32'(go_cnt - g0), 32'd0);
        check("gate_txl", 32'(tx_level), 32'd1);
        check("gate_idle", 32'(idle), 32'd0);
        enable = 1'b1;
        tick(1);
        check("gate_go", 32'(spi_go), 32'd1);
        tick(2);
        enable = 1'b0;
        n = 0;
        while (!rx_valid && n < 200) begin tick(1); n++; end
        check("gate_rxd", 32'(rx_data), 32'hC3);
        tick(20);
        check("gate_gos1", 32'(go_cnt - g0), 32'd1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        enable = 1'b1;

        // Reset during WAIT_DONE
        g0 = go_cnt;
        push_word(8'h77);
        n = 0;
        while (slv_cnt == 0 && n < 50) begin tick(1); n++; end
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_txl", 32'(tx_level), 32'd0);
        check("arst_rxl", 32'(rx_level), 32'd0);
        check("arst_go", 32'(spi_go), 32'd0);
        check("arst_rxv", 32'(rx_valid), 32'd0);
        check("arst_txd", 32'(spi_tx_data), 32'd0);
        exp_q.delete();
        tick(2);
        rst_n = 1'b1;
        tick(50);
        check("post_rst_rxl", 32'(rx_level), 32'd0);
        check("post_rst_rxv", 32'(rx_valid), 32'd0);
        check("post_rst_gos", 32'(go_cnt - g0), 32'd1);

`ifdef SPI_SEQ_STATS_EN
        check("stats_rst", 32'(xfer_count), 32'd0);
        for (int i = 0; i < 3; i++) push_word(DL'(8'h40 + i));
        n = 0;
        while (!(rx_level == LW'(3) && idle) && n < 500) begin tick(1); n++; end
        check("stats_xfer", 32'(xfer_count), 32'd3);
        push_word(8'h50);
        push_word(8'h51);
        n = 0;
        while (!(rx_level == LW'(FD) && tx_level == LW'(1)) && n < 500) begin tick(1); n++; end
        tick(40);
        s0 = stall_cycles;
        tick(10);
        check("stats_stall", 32'(stall_cycles - s0), 32'd10);
        rx_ready = 1'b1;
        n = 0;
        while (!(exp_q.size() == 0 && idle && slv_cnt == 0) && n < 1000) begin tick(1); n++; end
        rx_ready = 1'b0;
        check("stats_xfer5", 32'(xfer_count), 32'd5);
`endif

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
